// File: rtl/eth_rx_pkg.sv
// Shared types for the RX dispatcher: FSM states, delay-line entry, channel IDs and selector matcher.
// Pure declarations; no latency or backpressure of its own.
package eth_rx_pkg;

    localparam int NCH = 4;

    localparam logic [7:0] DEF_CH0_ID = 8'h10;
    localparam logic [7:0] DEF_CH1_ID = 8'h11;
    localparam logic [7:0] DEF_CH2_ID = 8'h12;
    localparam logic [7:0] DEF_CH3_ID = 8'h13;

    typedef enum logic [1:0] {IDLE, HDR, PASS} cls_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_ACT, OUT_DROP} out_state_t;

    typedef struct packed {
        logic       v;
        logic       sof;
        logic       eof;
        logic [7:0] dat;
    } line_t;

    // Returns {hit, ch}; the lowest-numbered matching channel wins.
    function automatic logic [2:0] sel_match(input logic [7:0] b, input logic [7:0] id0,
                                             input logic [7:0] id1, input logic [7:0] id2,
                                             input logic [7:0] id3);
        if (b == id0) return 3'b100;
        if (b == id1) return 3'b101;
        if (b == id2) return 3'b110;
        if (b == id3) return 3'b111;
        return 3'b000;
    endfunction

endpackage

// File: rtl/eth_rx_delay_line.sv
// Fixed-depth shift register of qualified RX bytes; DEPTH cycles latency, shifts every cycle, no backpressure.
module eth_rx_delay_line
    import eth_rx_pkg::*;
#(
    parameter int DEPTH = 38
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  line_t d_i,
    output line_t q_o
);

    line_t stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/eth_rx_dispatcher.sv
// Routes whole RX frames to one of 4 channels by the byte at SEL_OFFSET; fixed SEL_OFFSET+2 latency, no backpressure.
// Unmatched/runt frames are dropped; defining ETH_RX_STATS_EN adds saturating DropCnt/AbortCnt outputs.
module eth_rx_dispatcher
    import eth_rx_pkg::*;
#(
    parameter int         SEL_OFFSET = 37,
    parameter logic [7:0] CH0_ID     = DEF_CH0_ID,
    parameter logic [7:0] CH1_ID     = DEF_CH1_ID,
    parameter logic [7:0] CH2_ID     = DEF_CH2_ID,
    parameter logic [7:0] CH3_ID     = DEF_CH3_ID
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           LINK_UP,
    input  logic           ValIn,
    input  logic           SoFIn,
    input  logic           EoFIn,
    input  logic [7:0]     DataIn,
    output logic [NCH-1:0] ValOut,
    output logic [NCH-1:0] SoFOut,
    output logic [NCH-1:0] EoFOut,
    output logic [7:0]     DataOut,
    output logic [NCH-1:0] AbortOut
`ifdef ETH_RX_STATS_EN
    ,
    output logic [15:0]    DropCnt,
    output logic [15:0]    AbortCnt
`endif
);

    localparam logic [5:0] SEL = 6'(SEL_OFFSET);

    logic       v;
    logic [2:0] m;
    line_t      din;
    line_t      dl;

    assign v   = ValIn & LINK_UP;
    assign din = {v, v & SoFIn, v & EoFIn, DataIn};
    assign m   = sel_match(DataIn, CH0_ID, CH1_ID, CH2_ID, CH3_ID);

    eth_rx_delay_line #(.DEPTH(SEL_OFFSET + 1)) u_line (
        .clk_i (Clk),
        .rst_i (Rst),
        .d_i   (din),
        .q_o   (dl)
    );

    cls_state_t cst_q;
    logic [5:0] cnt_q;
    logic [1:0] pend_ch_q;
    logic       pend_hit_q;

    // A new SoF always clears PendHit; the previous decision was already consumed by then.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cst_q      <= IDLE;
            cnt_q      <= '0;
            pend_ch_q  <= '0;
            pend_hit_q <= 1'b0;
        end else if (!LINK_UP) begin
            cst_q <= IDLE;
        end else if (v && SoFIn) begin
            cnt_q      <= 6'd1;
            pend_hit_q <= 1'b0;
            cst_q      <= EoFIn ? IDLE : HDR;
        end else if (v) begin
            if (cnt_q != 6'h3F) cnt_q <= cnt_q + 6'd1;
            case (cst_q)
                HDR: begin
                    if (cnt_q == SEL) begin
                        pend_ch_q  <= m[1:0];
                        pend_hit_q <= m[2];
                        cst_q      <= EoFIn ? IDLE : PASS;
                    end else if (EoFIn) begin
                        cst_q <= IDLE;
                    end
                end
                PASS:    if (EoFIn) cst_q <= IDLE;
                default: ;
            endcase
        end
    end

    out_state_t     ost_q;
    logic [1:0]     act_q;
    logic [NCH-1:0] val_q, sof_q, eof_q, abort_q;
    logic [7:0]     data_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ost_q   <= OUT_IDLE;
            act_q   <= '0;
            val_q   <= '0;
            sof_q   <= '0;
            eof_q   <= '0;
            abort_q <= '0;
            data_q  <= '0;
        end else begin
            val_q   <= '0;
            sof_q   <= '0;
            eof_q   <= '0;
            abort_q <= '0;
            data_q  <= '0;
            if (dl.v && dl.sof) begin
                if (ost_q == OUT_ACT) abort_q[act_q] <= 1'b1;
                act_q <= pend_ch_q;
                ost_q <= dl.eof ? OUT_IDLE : (pend_hit_q ? OUT_ACT : OUT_DROP);
                if (pend_hit_q) begin
                    val_q[pend_ch_q] <= 1'b1;
                    sof_q[pend_ch_q] <= 1'b1;
                    eof_q[pend_ch_q] <= dl.eof;
                    data_q           <= dl.dat;
                end
            end else begin
                case (ost_q)
                    OUT_ACT: begin
                        // A gap inside an active frame means its EoF never made it in.
                        if (!dl.v) begin
                            abort_q[act_q] <= 1'b1;
                            ost_q          <= OUT_IDLE;
                        end else begin
                            val_q[act_q] <= 1'b1;
                            eof_q[act_q] <= dl.eof;
                            data_q       <= dl.dat;
                            if (dl.eof) ost_q <= OUT_IDLE;
                        end
                    end
                    OUT_DROP: if (!dl.v || dl.eof) ost_q <= OUT_IDLE;
                    default:  ;
                endcase
            end
        end
    end

    assign ValOut   = val_q;
    assign SoFOut   = sof_q;
    assign EoFOut   = eof_q;
    assign DataOut  = data_q;
    assign AbortOut = abort_q;

`ifdef ETH_RX_STATS_EN
    logic        drop_evt, abort_evt;
    logic [15:0] drop_cnt_q, drop_cnt_d, abort_cnt_q, abort_cnt_d;

    assign drop_evt  = dl.v & dl.sof & ~pend_hit_q;
    assign abort_evt = (ost_q == OUT_ACT) & (~dl.v | dl.sof);

    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        abort_cnt_d = abort_cnt_q;
        if (drop_evt && drop_cnt_q != 16'hFFFF)   drop_cnt_d  = drop_cnt_q + 16'd1;
        if (abort_evt && abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            drop_cnt_q  <= '0;
            abort_cnt_q <= '0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign DropCnt  = drop_cnt_q;
    assign AbortCnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_eth_rx_dispatcher.sv
// Bench for eth_rx_dispatcher: directed frame table, corner sequences, and random traffic against a frame-level model.
module tb_eth_rx_dispatcher;

    localparam int L    = 39;
    localparam int SEL  = 37;
    localparam int MAXC = 20000;

    logic       Clk = 1'b0;
    logic       Rst, LINK_UP, ValIn, SoFIn, EoFIn;
    logic [7:0] DataIn;
    logic [3:0] ValOut, SoFOut, EoFOut, AbortOut;
    logic [7:0] DataOut;
`ifdef ETH_RX_STATS_EN
    logic [15:0] DropCnt, AbortCnt;
`endif

    eth_rx_dispatcher dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .LINK_UP  (LINK_UP),
        .ValIn    (ValIn),
        .SoFIn    (SoFIn),
        .EoFIn    (EoFIn),
        .DataIn   (DataIn),
        .ValOut   (ValOut),
        .SoFOut   (SoFOut),
        .EoFOut   (EoFOut),
        .DataOut  (DataOut),
        .AbortOut (AbortOut)
`ifdef ETH_RX_STATS_EN
        ,
        .DropCnt  (DropCnt),
        .AbortCnt (AbortCnt)
`endif
    );

    always #5 Clk = ~Clk;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    bit         in_v [MAXC];
    bit         in_sof [MAXC];
    bit         in_eof [MAXC];
    logic [7:0] in_dat [MAXC];
    logic [3:0] out_val [MAXC], out_sof [MAXC], out_eof [MAXC], out_ab [MAXC];
    logic [7:0] out_dat [MAXC];
    logic [3:0] e_val [MAXC], e_sof [MAXC], e_eof [MAXC], e_ab [MAXC];
    logic [7:0] e_dat [MAXC];

    always @(negedge Clk) begin
        if (cyc < MAXC) begin
            out_val[cyc] = ValOut;
            out_sof[cyc] = SoFOut;
            out_eof[cyc] = EoFOut;
            out_ab[cyc]  = AbortOut;
            out_dat[cyc] = DataOut;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input bit v, input bit sof, input bit eof, input logic [7:0] d, input bit lk);
        if (cyc >= MAXC - 200) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 200);
            $fatal(1, "cycle budget exhausted");
        end
        ValIn = v; SoFIn = sof; EoFIn = eof; DataIn = d; LINK_UP = lk;
        in_v[cyc]   = v & lk & !Rst;
        in_sof[cyc] = v & lk & sof & !Rst;
        in_eof[cyc] = v & lk & eof & !Rst;
        in_dat[cyc] = d;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 8'h00, 1);
    endtask

    // Sends bytes 0..len-1 (or 0..cut-1 when cut>=0, leaving the frame without EoF).
    task automatic send_frame(input int len, input logic [7:0] sel, input int cut, output int s);
        s = cyc;
        for (int b = 0; b < len; b++) begin
            if (cut >= 0 && b == cut) break;
            tick(1, b == 0, b == len - 1, (b == SEL) ? sel : 8'($urandom), 1);
        end
    endtask

    function automatic logic [3:0] pick(input int kind, input int c);
        case (kind)
            0:       return out_val[c];
            1:       return out_sof[c];
            2:       return out_eof[c];
            3:       return out_ab[c];
            default: return 4'b0;
        endcase
    endfunction

    function automatic int tally(input int kind, input int ch, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++)
            n += (ch == 4) ? $countones(pick(kind, c)) : int'(pick(kind, c)[ch]);
        return n;
    endfunction

    function automatic int first_of(input int kind, input int ch, input int lo, input int hi);
        for (int c = lo; c <= hi; c++)
            if (pick(kind, c)[ch]) return c;
        return -1;
    endfunction

    function automatic int overlap(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if ($countones(out_val[c]) > 1) n++;
        return n;
    endfunction

    // Frame-level reference: parse the recorded byte stream into frames, decide each from its byte 37.
    task automatic run_model(input int n, output int drops, output int aborts);
        drops = 0;
        aborts = 0;
        for (int c = 0; c < MAXC; c++) begin
            e_val[c] = '0; e_sof[c] = '0; e_eof[c] = '0; e_ab[c] = '0; e_dat[c] = '0;
        end
        for (int c = 0; c < n;) begin
            if (in_v[c] && in_sof[c]) begin
                int j, tc, ch;
                bit trunc, done;
                j = c; tc = 0; ch = -1; trunc = 0; done = 0;
                while (!done) begin
                    if (in_eof[j]) done = 1;
                    else if (j + 1 >= n || !in_v[j+1] || in_sof[j+1]) begin
                        trunc = 1; tc = j + 1; done = 1;
                    end else j++;
                end
                if (j - c + 1 > SEL && in_dat[c+SEL] >= 8'h10 && in_dat[c+SEL] <= 8'h13)
                    ch = int'(in_dat[c+SEL]) - 16;
                if (ch < 0) drops++;
                else begin
                    for (int b = c; b <= j; b++) begin
                        e_val[b+L][ch] = 1'b1;
                        e_dat[b+L]     = in_dat[b];
                    end
                    e_sof[c+L][ch] = 1'b1;
                    if (!trunc) e_eof[j+L][ch] = 1'b1;
                    else begin
                        e_ab[tc+L][ch] = 1'b1;
                        aborts++;
                    end
                end
                c = j + 1;
            end else c++;
        end
    endtask

    typedef struct {
        int         len;
        logic [7:0] sel;
        int         cut;
        int         ch;
        int         nval;
        int         neof;
        int         nab;
    } vec_t;

    vec_t tbl [10];
    int   s, s1, s2, lo, hi, n, drops, aborts, r, len, cut, k;
    logic [7:0] sel;

    initial begin
        tbl[0] = '{60, 8'h12, -1,  2, 60, 1, 0};
        tbl[1] = '{60, 8'h55, -1, -1,  0, 0, 0};
        tbl[2] = '{20, 8'h10, -1, -1,  0, 0, 0};
        tbl[3] = '{38, 8'h11, -1,  1, 38, 1, 0};
        tbl[4] = '{37, 8'h10, -1, -1,  0, 0, 0};
        tbl[5] = '{60, 8'h11, 50,  1, 50, 0, 1};
        tbl[6] = '{60, 8'h13, 20, -1,  0, 0, 0};
        tbl[7] = '{ 1, 8'h10, -1, -1,  0, 0, 0};
        tbl[8] = '{64, 8'h10, -1,  0, 64, 1, 0};
        tbl[9] = '{40, 8'h13, -1,  3, 40, 1, 0};

        Rst = 1'b1; LINK_UP = 1'b1; ValIn = 1'b0; SoFIn = 1'b0; EoFIn = 1'b0; DataIn = 8'h00;
        for (int i = 0; i < 4; i++) tick(1, 1, 0, 8'h10, 1);
        Rst = 1'b0;
        @(negedge Clk);
        chk("rst_valout", ValOut, 0);
        chk("rst_sofout", SoFOut, 0);
        chk("rst_eofout", EoFOut, 0);
        chk("rst_dataout", DataOut, 0);
        chk("rst_abortout", AbortOut, 0);
`ifdef ETH_RX_STATS_EN
        chk("rst_dropcnt", DropCnt, 0);
        chk("rst_abortcnt", AbortCnt, 0);
`endif
        idle(5);

        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].len, tbl[i].sel, tbl[i].cut, s);
            if (tbl[i].cut >= 0) begin
                tick(1, 0, 0, 8'hA5, 0);
                tick(1, 1, 0, 8'h10, 0);
            end
            idle(50);
            hi = s + tbl[i].len + L + 3;
            chk($sformatf("t%0d_val_all", i), tally(0, 4, s, hi), tbl[i].nval);
            chk($sformatf("t%0d_abort_all", i), tally(3, 4, s, hi), tbl[i].nab);
            if (tbl[i].ch >= 0) begin
                chk($sformatf("t%0d_first_val", i), first_of(0, tbl[i].ch, s, hi), s + L);
                chk($sformatf("t%0d_val_ch", i), tally(0, tbl[i].ch, s, hi), tbl[i].nval);
                chk($sformatf("t%0d_eof_ch", i), tally(2, tbl[i].ch, s, hi), tbl[i].neof);
                chk($sformatf("t%0d_sof_ch", i), tally(1, tbl[i].ch, s, hi), 1);
            end
        end

        send_frame(60, 8'h10, -1, s1);
        send_frame(60, 8'h13, -1, s2);
        idle(50);
        lo = s1; hi = s2 + 60 + L + 3;
        chk("zifg_ch0", tally(0, 0, lo, hi), 60);
        chk("zifg_ch3", tally(0, 3, lo, hi), 60);
        chk("zifg_ch3_sof", first_of(1, 3, lo, hi), s2 + L);
        chk("zifg_back2back", first_of(1, 3, lo, hi), first_of(2, 0, lo, hi) + 1);
        chk("zifg_overlap", overlap(lo, hi), 0);

        send_frame(60, 8'h10, 45, s1);
        send_frame(50, 8'h12, -1, s2);
        idle(50);
        lo = s1; hi = s2 + 50 + L + 3;
        chk("restart_abort_at_sof", first_of(3, 0, lo, hi), first_of(1, 2, lo, hi));
        chk("restart_abort_cnt", tally(3, 0, lo, hi), 1);
        chk("restart_ch0_val", tally(0, 0, lo, hi), 45);
        chk("restart_ch0_eof", tally(2, 0, lo, hi), 0);
        chk("restart_ch2_val", tally(0, 2, lo, hi), 50);

        for (int f = 0; f < 120; f++) begin
            r   = $urandom_range(0, 99);
            len = (r < 30) ? $urandom_range(1, 37) : $urandom_range(38, 90);
            k   = $urandom_range(0, 4);
            sel = (k < 4) ? 8'(8'h10 + k) : 8'($urandom);
            r   = $urandom_range(0, 9);
            cut = (r < 2 && len > 1) ? $urandom_range(1, len - 1) : -1;
            send_frame(len, sel, cut, s);
            if (cut >= 0 && r == 0) begin
                k = $urandom_range(1, 3);
                for (int i = 0; i < k; i++) tick($urandom_range(0, 1), 0, 0, 8'h00, 0);
            end else if (cut < 0) begin
                idle($urandom_range(0, 3));
            end
        end
        idle(50);

        n = cyc;
        run_model(n, drops, aborts);
        for (int c = 1; c < n; c++)
            chk($sformatf("cyc%0d", c),
                {8'h0, out_ab[c], out_eof[c], out_sof[c], out_val[c], out_dat[c]},
                {8'h0, e_ab[c], e_eof[c], e_sof[c], e_val[c], e_dat[c]});
`ifdef ETH_RX_STATS_EN
        chk("model_dropcnt", DropCnt, drops);
        chk("model_abortcnt", AbortCnt, aborts);
`endif

        send_frame(60, 8'h12, -1, s);
        idle(5);
        lo = cyc + 1;
        Rst = 1'b1;
        idle(2);
        Rst = 1'b0;
        idle(60);
        hi = cyc - 1;
        chk("midrst_no_val", tally(0, 4, lo, hi), 0);
        chk("midrst_no_abort", tally(3, 4, lo, hi), 0);
`ifdef ETH_RX_STATS_EN
        chk("midrst_dropcnt", DropCnt, 0);
        chk("midrst_abortcnt", AbortCnt, 0);
`endif
        send_frame(60, 8'h13, -1, s);
        idle(45);
        chk("postrst_ch3", tally(0, 3, s, s + 60 + L + 3), 60);
        chk("postrst_first", first_of(0, 3, s, s + 60 + L + 3), s + L);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_rx_dispatcher.md
Name: eth_rx_dispatcher

Overview:
- Receive-side counterpart of the 4-channel Ethernet TX scheduler.
- Takes the single byte stream from the MAC RX path (Val/SoF/EoF/Data) and routes whole frames to one of 4 channel consumers.
- The channel is selected by matching one header byte at a fixed offset, by default the UDP destination port low byte, against 4 channel IDs.
- Unmatched and runt frames are dropped.

Parameters:
- SEL_OFFSET, 37, byte index from SoF of the selector byte, range 1..63.
- CH0_ID, 8'h10, selector value routed to channel 0.
- CH1_ID, 8'h11, selector value routed to channel 1.
- CH2_ID, 8'h12, selector value routed to channel 2.
- CH3_ID, 8'h13, selector value routed to channel 3.

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous reset, active-high
- LINK_UP  in  1  link status; input is qualified by it
- ValIn  in  1  byte valid; contiguous within a frame
- SoFIn  in  1  first byte of frame, qualified by ValIn
- EoFIn  in  1  last byte of frame, qualified by ValIn
- DataIn  in  8  byte
- ValOut  out  4  per-channel byte valid, one-hot or zero
- SoFOut  out  4  per-channel start of frame
- EoFOut  out  4  per-channel end of frame
- DataOut  out  8  shared data, meaningful where ValOut!=0
- AbortOut  out  4  one-cycle pulse: the channel's current frame was truncated

Behaviour:
- Reset: all outputs 0, both FSMs idle, delay line cleared. Rst mid-frame discards the frame silently; no AbortOut.
- Input qualification: v = ValIn & LINK_UP. SoF/EoF are ignored unless v=1.
- Delay line: D=SEL_OFFSET+1 stages of {v,SoF,EoF,Data}, shifting every cycle. Outputs are registered after the line.
- Latency: input byte at cycle t appears on outputs at t+SEL_OFFSET+2. Latency is fixed; there is no backpressure.
- Classifier FSM, on the input side:
  - IDLE: on v&SoF, ByteCnt=1, go to HDR. If the same byte also has EoF, the frame is a runt: drop it.
  - HDR: on each v, ByteCnt++.
  - At ByteCnt==SEL_OFFSET with v, compare DataIn with CH0..CH3_ID, lowest index first. The result goes to PendCh/PendHit, then the FSM goes to PASS.
  - EoF before the selector byte: runt, PendHit=0.
  - PASS: wait for v&EoF, then go to IDLE.
  - ByteCnt is 6 bits and saturates.
- Dispatcher FSM, on the output side:
  - OUT_IDLE: on delayed SoF, load ActCh=PendCh. If PendHit, go to OUT_ACT; else go to OUT_DROP.
  - OUT_ACT: drive ValOut[ActCh]=dv, SoFOut[ActCh], EoFOut[ActCh], DataOut. Delayed EoF returns to OUT_IDLE.
  - OUT_DROP: suppress all outputs until delayed EoF.
  - Timing: the decision is registered the cycle after the selector byte, which coincides with the delayed SoF at the line output. Back-to-back frames, including those with zero IFG, cannot overwrite PendCh before it is consumed.
- Boundary cases:
  - SoF while the classifier is in HDR or PASS: restart classification for the new frame. Downstream, a delayed SoF in OUT_ACT pulses AbortOut[ActCh] in the same cycle and the new frame is dispatched normally.
  - LINK_UP falls mid-frame: the classifier goes to IDLE. When the line output reaches the missing-EoF point (delayed v=0 in OUT_ACT), pulse AbortOut[ActCh] and go to OUT_IDLE.
  - A frame exactly SEL_OFFSET+1 bytes long, with EoF on the selector byte, is a valid hit.
  - Simultaneous EoF and the next SoF on one byte cannot occur; SoF wins and an abort is counted.
  - DataOut is 0 whenever ValOut==0.

Optional Feature:
- Macro ETH_RX_STATS_EN.
- Defined: adds outputs DropCnt[15:0] and AbortCnt[15:0].
  - DropCnt increments on each dropped frame (unmatched or runt).
  - AbortCnt increments on each AbortOut pulse.
  - Both saturate at 16'hFFFF and are cleared by Rst.
- Undefined: no counters and no ports; all other behaviour is identical.

Decomposition:
- Package eth_rx_pkg:
  - classifier state enum: IDLE, HDR, PASS
  - dispatcher state enum: OUT_IDLE, OUT_ACT, OUT_DROP
  - NCH=4
  - default channel IDs
- Sub-module eth_rx_delay_line: parameterized-depth shift register of {v,SoF,EoF,Data}.

Test Plan:
- 60-byte frame with byte37=8'h12, contiguous -> ValOut=4'b0100 for 60 cycles starting t0+39; SoFOut[2] on first, EoFOut[2] on last; DataOut matches input.
- Frame with byte37=8'h55 -> no ValOut; DropCnt=1 (STATS_EN).
- 20-byte runt -> dropped, no outputs, DropCnt increments.
- Two zero-IFG frames, byte37=8'h10 then 8'h13 -> channel 0 frame, then channel 3 frame on the next cycle, no overlap.
- LINK_UP low at byte 50 of a channel-1 frame -> AbortOut[1] pulses once; no EoFOut[1]; next frame routes correctly.
- SoF at byte 45 of a channel-0 frame -> AbortOut[0] pulse coincident with the new SoF on its matched channel.
